lfsr_checker: RTL
=================

# lfsr_checker

Receive-side companion to the 10-bit LFSR generator: consumes the parallel 10-bit pseudo-random word stream, self-synchronises to it, declares lock, and counts sequence errors afterwards. Sits at the sink end of any link or datapath driven by the LFSR, giving built-in self-test with a pass/fail view.

## Interface
- LOCK_CNT, 4, consecutive correct predictions required in VERIFY before declaring lock (≥1)
- UNLOCK_CNT, 3, consecutive mispredictions in LOCKED that drop lock (≥1)
- ERR_W, 16, width of the saturating error counter
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  in_data carries a word this cycle
- in_data  in  10  received LFSR word
- clear_cnt  in  1  synchronous clear of err_count
- locked  out  1  checker is in LOCKED
- err_pulse  out  1  one-cycle strobe per mispredicted word while LOCKED
- err_count  out  ERR_W  saturating count of mispredicted words while LOCKED

## Operation
- Polynomial x^10 + x^7 + 1, Fibonacci form: next(q) = {q[8:0], q[9] ^ q[6]}. All-zero word is illegal (lock-up state).
- Registers: state, 10-bit predictor pred, match counter, miss counter, err_count.
- States HUNT, VERIFY, LOCKED. With in_valid low, nothing changes except clear_cnt.
- HUNT: valid nonzero word → pred <= in_data, match_cnt <= 0, go VERIFY. Zero word → stay HUNT.
- VERIFY: valid word == next(pred) → pred <= in_data, match_cnt++; LOCK_CNT-th consecutive match → LOCKED, miss_cnt <= 0. Mismatch, nonzero → pred <= in_data, match_cnt <= 0, stay VERIFY (resync). Mismatch, zero → HUNT. No errors counted outside LOCKED.
- LOCKED: match → pred <= in_data, miss_cnt <= 0. Mismatch → flywheel: pred <= next(pred) (received word ignored), err_pulse next cycle, err_count increments saturating at 2^ERR_W−1, miss_cnt++. UNLOCK_CNT-th consecutive mismatch → HUNT; that word still counts as an error.
- clear_cnt: err_count <= 0; coincident with an error increment, clear wins (result 0); err_pulse still fires.
- Reset: state HUNT, pred 0, counters 0, locked 0, err_pulse 0, err_count 0. Reset mid-lock drops locked immediately (asynchronous); relock needs a fresh LOCK_CNT+1 valid words.

## Timing
- All outputs registered; no combinational input-to-output path.
- Lock latency: with in_valid continuous, locked rises on the edge sampling word LOCK_CNT (words numbered from 0 at HUNT exit); i.e. LOCK_CNT+1 words.
- err_pulse and err_count update on the edge sampling the bad word; visible the following cycle; one pulse per bad word, back-to-back allowed.
- locked falls on the edge sampling the UNLOCK_CNT-th consecutive bad word.
- Gaps in in_valid are transparent: prediction advances only per valid word.

## Structure
- Package lfsr_pkg: LFSR_W = 10, tap positions (9, 6), function lfsr_next, checker state enum. Shared with the generator so both ends use one polynomial definition.
- One sub-module natural: lfsr_step (combinational next-state of a 10-bit word, used for prediction); everything else in lfsr_checker.

## Test plan
- Lock: reset, feed 001,002,004,008,010 continuously → locked=1 after 010; err_count=0; continue 020,040,081 → stays locked, no err_pulse.
- Single error: locked, send 021 in place of 020, then 040,081 → one err_pulse, err_count=1, locked stays 1 (flywheel predicts 040 correctly).
- Loss of lock: locked, send 3 corrupt words (3FF,3FF,3FF) → err_count=3, locked=0 after third; then 001..010 → relocks.
- Illegal/resync: in HUNT send 000 → stays HUNT; in VERIFY after 001,002 send 155 → match count resets, locks after 155 + 4 correct successors.
- Counter control: force 2^ERR_W−1 errors (ERR_W=4 build) → saturates at 15; clear_cnt coincident with an error → err_count=0, err_pulse=1.
- Reset and gaps: in_valid toggling 1/0 during lock sequence → locked after 5 valid words; assert rst_n low mid-lock for 3 ns off-edge → locked=0 immediately, err_count=0.

Source files
------------

// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared polynomial (x^10 + x^7 + 1) and checker state definitions
package lfsr_pkg;
  localparam int LFSR_W = 10;
  localparam int TAP_A  = 9;
  localparam int TAP_B  = 6;
  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} chk_state_t;
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
    return {q[LFSR_W-2:0], q[TAP_A] ^ q[TAP_B]};
  endfunction
endpackage

// File: rtl/lfsr_if.sv
// lfsr_if: received word stream and checker status bundle
interface lfsr_if #(parameter int ERR_W = 16);
  import lfsr_pkg::*;
  logic              in_valid;
  logic [LFSR_W-1:0] in_data;
  logic              clear_cnt;
  logic              locked;
  logic              err_pulse;
  logic [ERR_W-1:0]  err_count;
  modport master (output in_valid, in_data, clear_cnt, input locked, err_pulse, err_count);
  modport slave  (input in_valid, in_data, clear_cnt, output locked, err_pulse, err_count);
endinterface

// File: rtl/lfsr_step.sv
// lfsr_step: combinational next word of the 10-bit LFSR
module lfsr_step
  import lfsr_pkg::*;
(
  input  logic [LFSR_W-1:0] q,
  output logic [LFSR_W-1:0] q_next
);
  assign q_next = lfsr_next(q);
endmodule

// File: rtl/lfsr_checker.sv
// lfsr_checker: self-synchronising LFSR sequence checker with lock and error count
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 3,
  parameter int ERR_W      = 16
) (
  input logic   clk,
  input logic   rst_n,
  lfsr_if.slave bus
);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int UW = $clog2(UNLOCK_CNT + 1);
  chk_state_t        state;
  logic [LFSR_W-1:0] pred, pred_next;
  logic [MW-1:0]     match_cnt;
  logic [UW-1:0]     miss_cnt;
  logic              locked_q, err_pulse_q;
  logic [ERR_W-1:0]  err_count_q;
  logic              match, nz;
  lfsr_step u_step (.q(pred), .q_next(pred_next));
  assign match         = bus.in_data == pred_next;
  assign nz            = |bus.in_data;
  assign bus.locked    = locked_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_count = err_count_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HUNT;
      pred        <= '0;
      match_cnt   <= '0;
      miss_cnt    <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      err_pulse_q <= 1'b0;
      if (bus.clear_cnt) err_count_q <= '0;
      if (bus.in_valid) begin
        case (state)
          HUNT: if (nz) begin
            pred      <= bus.in_data;
            match_cnt <= '0;
            state     <= VERIFY;
          end
          VERIFY: if (match) begin
            pred <= bus.in_data;
            if (match_cnt == MW'(LOCK_CNT - 1)) begin
              state    <= LOCKED;
              locked_q <= 1'b1;
              miss_cnt <= '0;
            end else match_cnt <= match_cnt + MW'(1);
          end else if (nz) begin
            pred      <= bus.in_data;
            match_cnt <= '0;
          end else state <= HUNT;
          LOCKED: if (match) begin
            pred     <= bus.in_data;
            miss_cnt <= '0;
          end else begin
            // flywheel: keep predicting from our own sequence, ignore the bad word
            pred        <= pred_next;
            err_pulse_q <= 1'b1;
            if (!bus.clear_cnt && err_count_q != '1) err_count_q <= err_count_q + ERR_W'(1);
            if (miss_cnt == UW'(UNLOCK_CNT - 1)) begin
              state    <= HUNT;
              locked_q <= 1'b0;
            end else miss_cnt <= miss_cnt + UW'(1);
          end
          default: state <= HUNT;
        endcase
      end
    end
  end
endmodule
